inst_fetch_unit: RTL and testbench

Instruction-fetch initiator for the byte-addressed, big-endian instruction memory.
- Drives the memory's fetch address and read/write strobe, and captures the combinational 32-bit read word.
- Buffers fetched words with their PCs in a small prefetch queue and hands them to decode over a valid/ready handshake.
- Handles control-flow redirects and faults on misaligned or out-of-range fetch addresses.

---
 rtl/inst_fetch_unit_pkg.sv | 19 +
 rtl/inst_fetch_unit_fetch_queue.sv | 53 +++++
 rtl/inst_fetch_unit.sv | 90 +++++++++
 tb/tb_inst_fetch_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and defaults for the instruction-fetch unit.
// Queue entries pair each fetched word with its byte address.
package inst_fetch_unit_pkg;

  localparam int          XLEN          = 32;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam int          MEM_BYTES_DEF = 300;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] word;
  } fq_entry_t;

endpackage

// File: rtl/inst_fetch_unit_fetch_queue.sv
// Prefetch FIFO of {pc, word} entries with flush.
// Head reads as zero whenever the queue is empty.
module fetch_queue
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  fq_entry_t       din,
  output logic [CW-1:0]   count,
  output fq_entry_t       head
);

  localparam int AW = $clog2(DEPTH);

  fq_entry_t      mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           do_pop;

  assign do_pop = pop && (count != '0);

  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  assign head = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: drives the read port, queues words for decode,
// and halts on misaligned or out-of-range fetch addresses.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          MEM_BYTES = MEM_BYTES_DEF,
  parameter int          DEPTH     = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic [31:0] IAddr,
  output logic        RW,
  output logic [31:0] IDataIn,
  input  logic [31:0] IDataOut,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  state_t          state;
  logic [31:0]     fetch_pc;
  logic [CW-1:0]   count;
  fq_entry_t       head;
  fq_entry_t       din;
  logic            pop;
  logic            push;
  logic            bad;
  logic            can_push;

  assign inst_valid = (count != '0);
  assign pop        = inst_valid & inst_ready;
  assign can_push   = (count < CW'(DEPTH)) | pop;
  assign bad        = (fetch_pc[1:0] != 2'b00) | (fetch_pc > LAST_PC);
  assign push       = !redirect_valid && (state == RUN) && !bad && can_push;
  assign din        = '{pc: fetch_pc, word: IDataOut};

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk   (CLK),
    .rst   (Reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (din),
    .count (count),
    .head  (head)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
      fault_pc <= '0;
    end else if (redirect_valid) begin
      state    <= RUN;
      fetch_pc <= redirect_pc;
    end else begin
      case (state)
        RUN: begin
          if (bad) begin
            state    <= FAULT;
            fault_pc <= fetch_pc;
          end else if (push) begin
            fetch_pc <= fetch_pc + 32'd4;
          end
        end
        FAULT: ;
        default: state <= RUN;
      endcase
    end
  end

  assign IAddr    = fetch_pc;
  assign RW       = 1'b1;
  assign IDataIn  = '0;
  assign fault    = (state == FAULT);
  assign inst     = head.word;
  assign inst_pc  = head.pc;
  assign inst_pc4 = inst_valid ? head.pc + 32'd4 : '0;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a behavioural memory
// and hand-computed expectations.
module tb_inst_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] IAddr;
  logic        RW;
  logic [31:0] IDataIn;
  logic [31:0] IDataOut;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;
  logic        fault;
  logic [31:0] fault_pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  inst_fetch_unit dut (
    .CLK            (CLK),
    .Reset          (Reset),
    .IAddr          (IAddr),
    .RW             (RW),
    .IDataIn        (IDataIn),
    .IDataOut       (IDataOut),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_pc4       (inst_pc4),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h2008_0005;
      32'h4:   return 32'h2009_0003;
      32'h8:   return 32'h0109_5020;
      default: return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endcase
  endfunction

  always_comb IDataOut = mem_word(IAddr);

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #4;
    Reset = 1'b0;
  endtask

  initial begin
    int exp_pc;
    int delivered;
    int last_pc;
    bit order_ok;
    bit saw_fault;

    Reset          = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #12;
    Reset = 1'b0;

    check("rst_valid", inst_valid, 0);
    check("rst_iaddr", IAddr, 32'h0);
    check("rst_rw", RW, 1);
    check("rst_idatain", IDataIn, 0);
    check("rst_fault", fault, 0);
    check("rst_fault_pc", fault_pc, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_inst_pc4", inst_pc4, 0);

    // Streaming with decode always ready
    inst_ready = 1'b1;
    step();
    check("t1_valid0", inst_valid, 1);
    check("t1_pc0", inst_pc, 32'h0);
    check("t1_inst0", inst, 32'h2008_0005);
    check("t1_pc4_0", inst_pc4, 32'h4);
    step();
    check("t1_pc1", inst_pc, 32'h4);
    check("t1_inst1", inst, 32'h2009_0003);
    check("t1_pc4_1", inst_pc4, 32'h8);
    step();
    check("t1_pc2", inst_pc, 32'h8);
    check("t1_inst2", inst, 32'h0109_5020);
    check("t1_pc4_2", inst_pc4, 32'hC);

    // Back-pressure fills the queue and holds the fetch address
    inst_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_valid", inst_valid, 1);
      check("t2_head", inst_pc, 32'h0);
    end
    check("t2_iaddr", IAddr, 32'h8);
    inst_ready = 1'b1;
    step();
    check("t2_pc1", inst_pc, 32'h4);
    check("t2_inst1", inst, 32'h2009_0003);
    step();
    check("t2_pc2", inst_pc, 32'h8);
    check("t2_iaddr2", IAddr, 32'h10);

    // Redirect while full with a simultaneous pop
    inst_ready = 1'b0;
    do_reset();
    step();
    step();
    step();
    check("t3_full_iaddr", IAddr, 32'h8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    inst_ready     = 1'b1;
    step();
    redirect_valid = 1'b0;
    check("t3_valid_gap", inst_valid, 0);
    check("t3_iaddr", IAddr, 32'h20);
    check("t3_inst_zero", inst, 0);
    check("t3_pc_zero", inst_pc, 0);
    step();
    check("t3_valid", inst_valid, 1);
    check("t3_pc", inst_pc, 32'h20);
    check("t3_inst", inst, 32'hC0DE_0020);

    // Misaligned redirect target faults until redirected
    redirect_valid = 1'b1;
    redirect_pc    = 32'h22;
    step();
    redirect_valid = 1'b0;
    check("t4_valid_gap", inst_valid, 0);
    step();
    check("t4_fault", fault, 1);
    check("t4_fault_pc", fault_pc, 32'h22);
    for (int i = 0; i < 10; i++) begin
      step();
      check("t4_hold_valid", inst_valid, 0);
      check("t4_hold_fault", fault, 1);
      check("t4_hold_iaddr", IAddr, 32'h22);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    step();
    redirect_valid = 1'b0;
    check("t4_clear", fault, 0);
    check("t4_gap", inst_valid, 0);
    step();
    check("t4_valid", inst_valid, 1);
    check("t4_pc", inst_pc, 32'h0);

    // Free run to the end of memory
    exp_pc    = 0;
    delivered = 0;
    last_pc   = -1;
    order_ok  = 1'b1;
    saw_fault = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (fault) begin
        saw_fault = 1'b1;
        break;
      end
      if (inst_valid) begin
        if (inst_pc != 32'(exp_pc)) order_ok = 1'b0;
        last_pc = int'(inst_pc);
        exp_pc += 4;
        delivered++;
      end
      step();
    end
    check("t5_fault_seen", saw_fault, 1);
    check("t5_order", order_ok, 1);
    check("t5_last_pc", last_pc, 296);
    check("t5_delivered", delivered, 75);
    check("t5_fault_pc", fault_pc, 32'd300);
    check("t5_valid_off", inst_valid, 0);

    // Reset between edges while faulted
    #2;
    Reset = 1'b1;
    #1;
    check("t6_valid", inst_valid, 0);
    check("t6_fault", fault, 0);
    check("t6_iaddr", IAddr, 32'h0);
    check("t6_fault_pc", fault_pc, 0);
    #2;
    Reset = 1'b0;
    step();
    check("t6_resume_valid", inst_valid, 1);
    check("t6_resume_pc", inst_pc, 32'h0);
    check("t6_resume_inst", inst, 32'h2008_0005);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
